// File: rtl/hazard_pkg.sv
// hazard_pkg: shared opcodes, FSM encoding and register field positions for the hazard controller
package hazard_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

    localparam int REG_W   = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} state_t;
endpackage

// File: rtl/inst_reg_use.sv
// inst_reg_use: decodes source-register usage, load flag and register fields of an RV32I instruction
module inst_reg_use
    import hazard_pkg::*;
(
    input  logic [31:0]      inst,
    output logic             uses_rs1,
    output logic             uses_rs2,
    output logic             memread,
    output logic             is_branch,
    output logic [REG_W-1:0] rd,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2
);
    logic [6:0] opc;
    logic       unused_hi;

    assign opc       = inst[6:0];
    assign uses_rs2  = opc inside {OPC_RTYPE, OPC_STORE, OPC_BRANCH};
    assign uses_rs1  = uses_rs2 || (opc inside {OPC_OPIMM, OPC_LOAD});
    assign memread   = opc == OPC_LOAD;
    assign is_branch = opc == OPC_BRANCH;
    assign rd        = inst[RD_LSB +: REG_W];
    assign rs1       = inst[RS1_LSB +: REG_W];
    assign rs2       = inst[RS2_LSB +: REG_W];
    assign unused_hi = ^inst[31:25];
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / branch-flush / memory-wait sequencing for the 5-stage RV32I pipeline.
// Define STALL_PERF_EN to build the stall/flush/wait performance counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      id_inst_i,
    input  logic             branch_taken_i,
    input  logic             mem_access_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] perf_lu_o,
    output logic [CNT_W-1:0] perf_fl_o,
    output logic [CNT_W-1:0] perf_mw_o
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_nx;
    logic              ex_memread;
    logic [REG_W-1:0]  ex_rd;
    logic [WC_W-1:0]   wait_cnt, wait_cnt_nx;
    logic              uses_rs1, uses_rs2, memread, is_branch;
    logic [REG_W-1:0]  rd, rs1, rs2;
    logic              mem_wait, load_use, run_eval;

    inst_reg_use u_dec (
        .inst      (id_inst_i),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .memread   (memread),
        .is_branch (is_branch),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2)
    );

    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
    assign mem_wait = (state == RUN && mem_access_i && !mem_ready_i) ||
                      (state == MEM_WAIT && !mem_ready_i);
    // the MEM_WAIT release cycle is evaluated exactly like a RUN cycle
    assign run_eval = state != IDLE && !mem_wait;

    always_comb begin
        pipe_hold_o   = mem_wait;
        idex_bubble_o = state == IDLE || (run_eval && load_use);
        pc_write_o    = run_eval && !load_use;
        ifid_write_o  = run_eval && !load_use;
        ifid_flush_o  = run_eval && !load_use && is_branch && branch_taken_i;
        state_nx      = mem_wait ? MEM_WAIT : (state == MEM_WAIT || start_i) ? RUN : IDLE;
        wait_cnt_nx   = !mem_wait ? '0 :
                        wait_cnt == WC_W'(MEM_TIMEOUT) ? wait_cnt : wait_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ex_memread <= 1'b0;
            ex_rd      <= '0;
            wait_cnt   <= '0;
            mem_err_o  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (wait_cnt_nx == WC_W'(MEM_TIMEOUT))
                mem_err_o <= 1'b1;
            // clearing the shadow on a load-use bounds the stall to one cycle
            if (run_eval) begin
                ex_memread <= load_use ? 1'b0 : memread;
                ex_rd      <= load_use ? '0 : rd;
            end
        end
    end

`ifdef STALL_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_lu_o <= '0;
            perf_fl_o <= '0;
            perf_mw_o <= '0;
        end else begin
            perf_lu_o <= perf_lu_o + CNT_W'(run_eval && load_use);
            perf_fl_o <= perf_fl_o + CNT_W'(ifid_flush_o);
            perf_mw_o <= perf_mw_o + CNT_W'(pipe_hold_o);
        end
    end
`else
    assign perf_lu_o = '0;
    assign perf_fl_o = '0;
    assign perf_mw_o = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed-vector bench for hazard_stall_ctrl with MEM_TIMEOUT=4
module tb_hazard_stall_ctrl;
    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] LW_X5    = 32'h0000A283;
    localparam logic [31:0] ADD_X5   = 32'h00728333;
    localparam logic [31:0] LW_X0    = 32'h00002003;
    localparam logic [31:0] ADD_X0   = 32'h00700333;
    localparam logic [31:0] BEQ_X1   = 32'h00208463;
    localparam logic [31:0] BEQ_X5   = 32'h00228463;
    localparam logic [4:0]  C_IDLE   = 5'b00010;
    localparam logic [4:0]  C_RUN    = 5'b11000;
    localparam logic [4:0]  C_LU     = 5'b00010;
    localparam logic [4:0]  C_FLUSH  = 5'b11100;
    localparam logic [4:0]  C_HOLD   = 5'b00001;
`ifdef STALL_PERF_EN
    localparam int EXP_LU = 1, EXP_FL = 1, EXP_MW = 3;
`else
    localparam int EXP_LU = 0, EXP_FL = 0, EXP_MW = 0;
`endif

    logic        clk = 1'b0, rst, start, taken, acc, rdy;
    logic [31:0] inst;
    logic        pc_w, ifid_w, ifid_fl, bubble, hold, err;
    logic [15:0] p_lu, p_fl, p_mw;
    logic [4:0]  ctl;
    int          total = 0, bad = 0;

    hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .id_inst_i(inst),
        .branch_taken_i(taken), .mem_access_i(acc), .mem_ready_i(rdy),
        .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(ifid_fl),
        .idex_bubble_o(bubble), .pipe_hold_o(hold), .mem_err_o(err),
        .perf_lu_o(p_lu), .perf_fl_o(p_fl), .perf_mw_o(p_mw)
    );

    assign ctl = {pc_w, ifid_w, ifid_fl, bubble, hold};
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] in, input logic tk,
                        input logic a, input logic r, input logic [4:0] exp, input logic e);
        inst = in; taken = tk; acc = a; rdy = r;
        #2;
        chk({tag, "_ctl"}, 16'(ctl), 16'(exp));
        chk({tag, "_err"}, 16'(err), 16'(e));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inst = NOP; taken = 1'b0; acc = 1'b0; rdy = 1'b1;
        #3;
        chk("rst_ctl", 16'(ctl), 16'(C_IDLE));
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_perf", p_lu | p_fl | p_mw, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step("idle_hold", NOP, 0, 0, 1, C_IDLE, 0);
        start = 1'b1;
        step("idle_go", NOP, 0, 0, 1, C_IDLE, 0);
        step("lw_x5", LW_X5, 0, 0, 1, C_RUN, 0);
        step("lu_stall", ADD_X5, 0, 0, 1, C_LU, 0);
        step("lu_done", ADD_X5, 0, 0, 1, C_RUN, 0);
        step("lw_x0", LW_X0, 0, 0, 1, C_RUN, 0);
        step("x0_nostall", ADD_X0, 0, 0, 1, C_RUN, 0);
        step("br_flush", BEQ_X1, 1, 0, 1, C_FLUSH, 0);
        step("br_after", NOP, 0, 0, 1, C_RUN, 0);
        step("mw1", NOP, 0, 1, 0, C_HOLD, 0);
        step("mw2", NOP, 0, 1, 0, C_HOLD, 0);
        step("mw3", NOP, 0, 1, 0, C_HOLD, 0);
        step("mw_rel", NOP, 0, 1, 1, C_RUN, 0);
        chk("perf_lu", p_lu, 16'(EXP_LU));
        chk("perf_fl", p_fl, 16'(EXP_FL));
        chk("perf_mw", p_mw, 16'(EXP_MW));
        step("lw_x5_b", LW_X5, 0, 0, 1, C_RUN, 0);
        step("br_in_lu", BEQ_X5, 1, 0, 1, C_LU, 0);
        step("br_retry", BEQ_X5, 1, 0, 1, C_FLUSH, 0);
        step("lw_x5_c", LW_X5, 0, 0, 1, C_RUN, 0);
        step("mw_pend1", ADD_X5, 0, 1, 0, C_HOLD, 0);
        step("mw_pend2", ADD_X5, 0, 1, 0, C_HOLD, 0);
        step("mw_pend_rel", ADD_X5, 0, 1, 1, C_LU, 0);
        step("pend_done", ADD_X5, 0, 0, 1, C_RUN, 0);
        start = 1'b0;
        step("run_stop", NOP, 0, 0, 1, C_RUN, 0);
        start = 1'b1;
        step("stop_idle", NOP, 0, 0, 1, C_IDLE, 0);
        step("to1", NOP, 0, 1, 0, C_HOLD, 0);
        step("to2", NOP, 0, 1, 0, C_HOLD, 0);
        step("to3", NOP, 0, 1, 0, C_HOLD, 0);
        step("to4", NOP, 0, 1, 0, C_HOLD, 0);
        step("to5", NOP, 0, 1, 0, C_HOLD, 1);
        step("to6", NOP, 0, 1, 0, C_HOLD, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ctl", 16'(ctl), 16'(C_IDLE));
        chk("async_rst_err", 16'(err), 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst", NOP, 0, 1, 0, C_IDLE, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
